// File: rtl/user_io_spi_master.sv
// SPI mode-0 master that frames a user_io command byte plus up to four payload bytes,
// returning every byte clocked in from SPI_MISO.
`timescale 1ns/1ps
module user_io_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_code,
   input  logic [2:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic        rx_last,
   output logic        busy,
   output logic        SPI_SCK,
   output logic        SPI_MOSI,
   input  logic        SPI_MISO,
   output logic        SPI_SS_IO
);

   generate
      if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
         $error("user_io_spi_master: CLK_DIV must be in 2..255");
      end
   endgenerate

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SETUP    = 3'd1;
   localparam logic [2:0] S_SHIFT_LO = 3'd2;
   localparam logic [2:0] S_SHIFT_HI = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;
   localparam logic [2:0] S_GAP      = 3'd5;

   logic [2:0]  r_state;
   logic        r_ready_en;
   logic [7:0]  r_div;
   logic [2:0]  r_bit;
   logic [2:0]  r_byte;
   logic [2:0]  r_len;
   logic [7:0]  r_tx_shift;
   logic [31:0] r_payload;
   logic [7:0]  r_rx_shift;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic        r_rx_last;
   logic        r_sck;
   logic        r_ss;

   logic        w_div_done;
   logic        w_accept;

   assign w_div_done = (r_div == DIV_LAST);
   // r_ready_en keeps cmd_ready low during reset and until the first edge after release
   assign cmd_ready  = (r_state == S_IDLE) && r_ready_en;
   assign w_accept   = cmd_valid && cmd_ready;

   assign busy      = (r_state != S_IDLE);
   assign SPI_SCK   = r_sck;
   assign SPI_MOSI  = r_tx_shift[7];
   assign SPI_SS_IO = r_ss;
   assign rx_valid  = r_rx_valid;
   assign rx_data   = r_rx_data;
   assign rx_last   = r_rx_last;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ready_en <= 1'b0;
         r_div      <= '0;
         r_bit      <= '0;
         r_byte     <= '0;
         r_len      <= '0;
         r_tx_shift <= '0;
         r_payload  <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_last  <= 1'b0;
         r_sck      <= 1'b0;
         r_ss       <= 1'b1;
      end else begin
         r_ready_en <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_last  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_shift <= cmd_code;
                  r_payload  <= cmd_data;
                  r_len      <= (cmd_len > 3'd4) ? 3'd4 : cmd_len;
                  r_byte     <= '0;
                  r_bit      <= '0;
                  r_div      <= '0;
                  r_ss       <= 1'b0;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_div <= w_div_done ? 8'd0 : r_div + 8'd1;
               if (w_div_done) r_state <= S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
               r_div <= w_div_done ? 8'd0 : r_div + 8'd1;
               if (w_div_done) begin
                  r_sck      <= 1'b1;
                  r_rx_shift <= {r_rx_shift[6:0], SPI_MISO};
                  r_state    <= S_SHIFT_HI;
               end
            end
            S_SHIFT_HI: begin
               r_div <= w_div_done ? 8'd0 : r_div + 8'd1;
               if (w_div_done) begin
                  r_sck <= 1'b0;
                  if (r_bit == 3'd7) begin
                     r_bit      <= '0;
                     r_rx_valid <= 1'b1;
                     r_rx_data  <= r_rx_shift;
                     r_rx_last  <= (r_byte == r_len);
                     if (r_byte == r_len) begin
                        r_state <= S_HOLD;
                     end else begin
                        // next payload byte goes straight out, no extra SCK-low time
                        r_byte     <= r_byte + 3'd1;
                        r_tx_shift <= r_payload[7:0];
                        r_payload  <= r_payload >> 8;
                        r_state    <= S_SHIFT_LO;
                     end
                  end else begin
                     r_bit      <= r_bit + 3'd1;
                     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                     r_state    <= S_SHIFT_LO;
                  end
               end
            end
            S_HOLD: begin
               r_div <= w_div_done ? 8'd0 : r_div + 8'd1;
               if (w_div_done) begin
                  r_ss    <= 1'b1;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               r_div <= w_div_done ? 8'd0 : r_div + 8'd1;
               if (w_div_done) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_user_io_spi_master.sv
// Bench for user_io_spi_master: a mode-0 slave model on the SPI pins and a frame-level
// reference that predicts bytes, SCK count, SS-low time and receive pulses.
`timescale 1ns/1ps
module tb_user_io_spi_master;

   localparam int CLK_DIV = 4;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_code = '0;
   logic [2:0]  cmd_len = '0;
   logic [31:0] cmd_data = '0;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_last;
   logic        busy;
   logic        SPI_SCK;
   logic        SPI_MOSI;
   logic        SPI_MISO = 1'b0;
   logic        SPI_SS_IO;

   user_io_spi_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
      .busy(busy),
      .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_SS_IO(SPI_SS_IO)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // slave model and cumulative monitors, sampled on the falling edge
   logic [7:0] slave_bytes [0:4];
   int         sck_rises = 0, ss_low_cycles = 0, gap_cycles = 0, mosi_viol = 0, ss_falls = 0;
   int         bit_idx = 0;
   logic [7:0] sh = '0;
   logic       prev_sck = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0;
   logic [7:0] rcv_q[$];
   logic [7:0] rxd_q[$];
   logic       rxl_q[$];

   always @(negedge clk_sys) begin
      if (prev_ss && !SPI_SS_IO) begin
         ss_falls++;
         bit_idx  = 0;
         SPI_MISO = slave_bytes[0][7];
      end
      if (!SPI_SS_IO) ss_low_cycles++;
      if (SPI_SS_IO && busy) gap_cycles++;
      if (!prev_sck && SPI_SCK) begin
         sck_rises++;
         sh = {sh[6:0], SPI_MOSI};
         bit_idx++;
         if (bit_idx % 8 == 0) rcv_q.push_back(sh);
      end
      if (prev_sck && !SPI_SCK) begin
         if (bit_idx < 40) SPI_MISO = slave_bytes[bit_idx / 8][7 - (bit_idx % 8)];
         else SPI_MISO = 1'b0;
      end
      if (prev_sck && SPI_SCK && (SPI_MOSI !== prev_mosi)) mosi_viol++;
      if (rx_valid) begin
         rxd_q.push_back(rx_data);
         rxl_q.push_back(rx_last);
      end
      prev_sck  = SPI_SCK;
      prev_ss   = SPI_SS_IO;
      prev_mosi = SPI_MOSI;
   end

   function automatic logic [7:0] frame_byte(input logic [7:0] code, input logic [31:0] data, input int i);
      logic [31:0] sh_data;
      sh_data = data >> (8 * (i - 1));
      return (i == 0) ? code : sh_data[7:0];
   endfunction

   function automatic int n_bytes(input logic [2:0] len);
      return 1 + ((len > 3'd4) ? 4 : int'(len));
   endfunction

   task automatic wait_ready_and_accept();
      int t = 0;
      while (!cmd_ready && t < 1000) begin
         @(negedge clk_sys);
         t++;
      end
      if (t >= 1000) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk_sys);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 20000) begin
         @(negedge clk_sys);
         t++;
      end
      if (t >= 20000) check("idle_timeout", 32'd0, 32'd1);
   endtask

   // runs `frames` frames of the same command (cmd_valid held throughout) and checks them
   task automatic run_frames(input logic [7:0] code, input logic [2:0] len,
                             input logic [31:0] data, input int frames);
      int n, s_rise, s_ss, s_gap, s_rcv, s_rx, s_falls, t;
      n = n_bytes(len);
      s_rise = sck_rises; s_ss = ss_low_cycles; s_gap = gap_cycles;
      s_rcv = rcv_q.size(); s_rx = rxd_q.size(); s_falls = ss_falls;
      @(negedge clk_sys);
      cmd_valid = 1'b1; cmd_code = code; cmd_len = len; cmd_data = data;
      if (frames == 1) begin
         wait_ready_and_accept();
      end else begin
         t = 0;
         while (ss_falls < s_falls + frames && t < 20000) begin
            @(negedge clk_sys);
            t++;
         end
         if (t >= 20000) check("b2b_timeout", 32'd0, 32'd1);
      end
      #1;
      cmd_valid = 1'b0;
      cmd_code = 8'($urandom); cmd_len = 3'($urandom); cmd_data = $urandom;
      @(negedge clk_sys);
      wait_idle();
      check("sck_rises", 32'(sck_rises - s_rise), 32'(8 * n * frames));
      check("ss_low", 32'(ss_low_cycles - s_ss), 32'(frames * CLK_DIV * (2 + 16 * n)));
      check("gap", 32'(gap_cycles - s_gap), 32'(frames * CLK_DIV));
      check("rx_count", 32'(rxd_q.size() - s_rx), 32'(n * frames));
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < n; i++) begin
            if (s_rcv + f * n + i < rcv_q.size())
               check("mosi_byte", 32'(rcv_q[s_rcv + f * n + i]), 32'(frame_byte(code, data, i)));
            if (s_rx + f * n + i < rxd_q.size()) begin
               check("rx_data", 32'(rxd_q[s_rx + f * n + i]), 32'(slave_bytes[i]));
               check("rx_last", 32'(rxl_q[s_rx + f * n + i]), 32'(i == n - 1));
            end
         end
      end
   endtask

   task automatic random_slave();
      for (int i = 0; i < 5; i++) slave_bytes[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ss"}, 32'(SPI_SS_IO), 32'd1);
      check({tag, "_sck"}, 32'(SPI_SCK), 32'd0);
      check({tag, "_mosi"}, 32'(SPI_MOSI), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
      check({tag, "_rxv"}, 32'(rx_valid), 32'd0);
      check({tag, "_rxd"}, 32'(rx_data), 32'd0);
      check({tag, "_rxl"}, 32'(rx_last), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk_sys);
      reset = 1'b0;
      #1 check("ready_before_edge", 32'(cmd_ready), 32'd0);
      @(posedge clk_sys);
      #1 check("ready_after_edge", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int s_rx, t;
      for (int i = 0; i < 5; i++) slave_bytes[i] = 8'h00;
      repeat (3) @(negedge clk_sys);
      check_reset_outputs("reset");
      release_reset();

      // status write
      random_slave();
      run_frames(8'h1E, 3'd4, 32'h12345678, 1);
      // config-string read: command byte answer is don't-care, then "CENT"
      slave_bytes[0] = 8'($urandom); slave_bytes[1] = 8'h43; slave_bytes[2] = 8'h45;
      slave_bytes[3] = 8'h4E; slave_bytes[4] = 8'h54;
      run_frames(8'h14, 3'd4, 32'h0, 1);
      // zero-payload frame
      random_slave();
      run_frames(8'hA5, 3'd0, 32'h0, 1);
      // oversized length clamps to four payload bytes
      random_slave();
      run_frames(8'h77, 3'd7, 32'hDEADBEEF, 1);

      for (int k = 0; k < 6; k++) begin
         random_slave();
         run_frames(8'($urandom), 3'($urandom_range(0, 7)), $urandom, 1);
      end

      // reset in the middle of the third byte
      random_slave();
      s_rx = rxd_q.size();
      @(negedge clk_sys);
      cmd_valid = 1'b1; cmd_code = 8'h3C; cmd_len = 3'd4; cmd_data = $urandom;
      wait_ready_and_accept();
      #1 cmd_valid = 1'b0;
      t = 0;
      while (rxd_q.size() < s_rx + 2 && t < 5000) begin
         @(negedge clk_sys);
         t++;
      end
      if (t >= 5000) check("mid_frame_timeout", 32'd0, 32'd1);
      repeat ($urandom_range(2, 20)) @(negedge clk_sys);
      @(posedge clk_sys);
      #2 reset = 1'b1;
      #1 check_reset_outputs("abort");
      repeat (5) @(negedge clk_sys);
      release_reset();
      repeat (200) @(negedge clk_sys);
      check("no_replay_busy", 32'(busy), 32'd0);
      check("no_extra_rx", 32'(rxd_q.size() - s_rx), 32'd2);
      random_slave();
      run_frames(8'h5A, 3'd3, $urandom, 1);

      // cmd_valid held for two consecutive frames
      random_slave();
      run_frames(8'hC3, 3'd2, $urandom, 2);

      check("mosi_stable_while_sck_high", 32'(mosi_viol), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
